// File: rtl/audio_pkg.sv
// Shared audio-path types and constants: FSM states, channel codes, packed-word fields.
package audio_pkg;

    localparam int SAMPLE_WIDTH_DEF = 16;
    localparam int CH_W             = 16;

    localparam int LEFT_MSB  = 31;
    localparam int LEFT_LSB  = 16;
    localparam int RIGHT_MSB = 15;
    localparam int RIGHT_LSB = 0;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

    typedef enum logic [1:0] {ALIGN, DELAY, SHIFT, DRAIN} rx_state_e;

    // |s| for a two's complement sample; -32768 saturates to 32767
    function automatic logic [CH_W-1:0] mag_sat(input logic [CH_W-1:0] s);
        if (!s[CH_W-1])
            return s;
        else if (s == {1'b1, {(CH_W-1){1'b0}}})
            return {1'b0, {(CH_W-1){1'b1}}};
        else
            return CH_W'(-s);
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous pin with rise/fall/any-edge pulses.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall,
    output logic edge_any
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign sync     = chain[SYNC_STAGES-1];
    assign rise     = sync & ~prev;
    assign fall     = ~sync & prev;
    assign edge_any = sync ^ prev;

endmodule

// File: rtl/i2s_adc_rx.sv
// I2S ADC deserializer: packs each left+right frame into {left, right} with a valid strobe.
// Optional peak-magnitude hold outputs are built when I2S_PEAK_HOLD_EN is defined.
module i2s_adc_rx
    import audio_pkg::*;
#(
    parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
    parameter int SYNC_STAGES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        AUD_BCLK,
    input  logic        AUD_ADCLRCK,
    input  logic        AUD_ADCDAT,
`ifdef I2S_PEAK_HOLD_EN
    input  logic        peakClr,
    output logic [15:0] peakLeft,
    output logic [15:0] peakRight,
`endif
    output logic [31:0] audioIn,
    output logic        sampleValid,
    output logic        frameError
);

    localparam int CNT_W = (SAMPLE_WIDTH > 1) ? $clog2(SAMPLE_WIDTH) : 1;

    logic bclk_rise;
    logic lr_edge, lr_fall;
    logic dat_s;
    logic bclk_sync_unused, bclk_fall_unused, bclk_edge_unused;
    logic lr_sync_unused, lr_rise_unused;
    logic dat_rise_unused, dat_fall_unused, dat_edge_unused;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_bclk (
        .clk(clk), .rst(rst), .din(AUD_BCLK),
        .sync(bclk_sync_unused), .rise(bclk_rise), .fall(bclk_fall_unused), .edge_any(bclk_edge_unused)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_lrck (
        .clk(clk), .rst(rst), .din(AUD_ADCLRCK),
        .sync(lr_sync_unused), .rise(lr_rise_unused), .fall(lr_fall), .edge_any(lr_edge)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_dat (
        .clk(clk), .rst(rst), .din(AUD_ADCDAT),
        .sync(dat_s), .rise(dat_rise_unused), .fall(dat_fall_unused), .edge_any(dat_edge_unused)
    );

    rx_state_e               state, state_nx;
    logic                    chan, chan_nx;
    logic [CNT_W-1:0]        bit_cnt, cnt_nx;
    logic [SAMPLE_WIDTH-1:0] shreg, shreg_nx, word_in;
    logic [CH_W-1:0]         left_hold, hold_nx;
    logic [31:0]             audio_nx;
    logic                    valid_nx, err_nx;
    rx_state_e               slot_st;

    // Narrower samples are left-justified into the 16-bit field
    function automatic logic [CH_W-1:0] to_field(input logic [SAMPLE_WIDTH-1:0] w);
        return CH_W'({w, {CH_W{1'b0}}} >> SAMPLE_WIDTH);
    endfunction

    assign word_in = {shreg[SAMPLE_WIDTH-2:0], dat_s};
    // A bclkRise coinciding with the LR edge already is the new slot's delay bit
    assign slot_st = bclk_rise ? SHIFT : DELAY;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ALIGN;
            chan        <= CH_LEFT;
            bit_cnt     <= '0;
            shreg       <= '0;
            left_hold   <= '0;
            audioIn     <= '0;
            sampleValid <= 1'b0;
            frameError  <= 1'b0;
        end else begin
            state       <= state_nx;
            chan        <= chan_nx;
            bit_cnt     <= cnt_nx;
            shreg       <= shreg_nx;
            left_hold   <= hold_nx;
            audioIn     <= audio_nx;
            sampleValid <= valid_nx;
            frameError  <= err_nx;
        end
    end

    always_comb begin
        state_nx = state;
        chan_nx  = chan;
        cnt_nx   = bit_cnt;
        shreg_nx = shreg;
        hold_nx  = left_hold;
        audio_nx = audioIn;
        valid_nx = 1'b0;
        err_nx   = 1'b0;
        case (state)
            ALIGN: begin
                if (lr_fall) begin
                    state_nx = slot_st;
                    chan_nx  = CH_LEFT;
                    cnt_nx   = '0;
                    shreg_nx = '0;
                end
            end
            DELAY, SHIFT: begin
                if (lr_edge) begin
                    // Short slot: drop the partial word and any pending left half
                    err_nx   = 1'b1;
                    hold_nx  = '0;
                    cnt_nx   = '0;
                    shreg_nx = '0;
                    if (lr_fall) begin
                        state_nx = slot_st;
                        chan_nx  = CH_LEFT;
                    end else begin
                        state_nx = ALIGN;
                    end
                end else if (bclk_rise) begin
                    if (state == DELAY) begin
                        state_nx = SHIFT;
                        cnt_nx   = '0;
                    end else begin
                        shreg_nx = word_in;
                        cnt_nx   = bit_cnt + 1'b1;
                        if (bit_cnt == CNT_W'(SAMPLE_WIDTH-1)) begin
                            state_nx = DRAIN;
                            if (chan == CH_LEFT) begin
                                hold_nx = to_field(word_in);
                            end else begin
                                audio_nx = {left_hold, to_field(word_in)};
                                valid_nx = 1'b1;
                            end
                        end
                    end
                end
            end
            DRAIN: begin
                if (lr_edge) begin
                    cnt_nx   = '0;
                    shreg_nx = '0;
                    if ((lr_fall ? CH_LEFT : CH_RIGHT) == chan) begin
                        err_nx   = 1'b1;
                        state_nx = ALIGN;
                    end else begin
                        state_nx = slot_st;
                        chan_nx  = ~chan;
                    end
                end
            end
            default: state_nx = ALIGN;
        endcase
    end

`ifdef I2S_PEAK_HOLD_EN
    logic [CH_W-1:0] mag_l, mag_r;

    assign mag_l = mag_sat(audio_nx[LEFT_MSB:LEFT_LSB]);
    assign mag_r = mag_sat(audio_nx[RIGHT_MSB:RIGHT_LSB]);

    always_ff @(posedge clk) begin
        if (rst) begin
            peakLeft  <= '0;
            peakRight <= '0;
        end else if (valid_nx) begin
            peakLeft  <= (peakClr || mag_l > peakLeft)  ? mag_l : peakLeft;
            peakRight <= (peakClr || mag_r > peakRight) ? mag_r : peakRight;
        end
    end
`endif

endmodule

// File: tb/tb_i2s_adc_rx.sv
// Bench for i2s_adc_rx: drives an I2S bit stream and checks delivered pairs and frame errors.
module tb_i2s_adc_rx;

    localparam int HALF = 40;  // BCLK half period = 4 clk

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        bclk = 1'b1;
    logic        lrck = 1'b1;
    logic        dat  = 1'b0;
    logic [31:0] audioIn;
    logic        sampleValid, frameError;
`ifdef I2S_PEAK_HOLD_EN
    logic        peakClr = 1'b0;
    logic [15:0] peakLeft, peakRight;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int err_seen = 0;
    logic [31:0] obs_q[$];
    logic [31:0] exp_q[$];

    i2s_adc_rx dut (
        .clk(clk), .rst(rst),
        .AUD_BCLK(bclk), .AUD_ADCLRCK(lrck), .AUD_ADCDAT(dat),
`ifdef I2S_PEAK_HOLD_EN
        .peakClr(peakClr), .peakLeft(peakLeft), .peakRight(peakRight),
`endif
        .audioIn(audioIn), .sampleValid(sampleValid), .frameError(frameError)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (sampleValid === 1'b1) obs_q.push_back(audioIn);
            if (frameError === 1'b1) err_seen++;
        end
    end

    // One channel slot: period 0 is the delay bit, word MSB-first after it, junk beyond 16 bits
    task automatic send_slot(input logic lr, input logic [15:0] w, input int periods,
                             input int rst_pulse_at, input int rst_release_at);
        for (int p = 0; p < periods; p++) begin
            bclk = 1'b0;
            lrck = lr;
            dat  = (p >= 1 && p <= 16) ? w[16-p] : 1'($urandom_range(0, 1));
            if (p == rst_release_at) rst = 1'b0;
            if (p == rst_pulse_at) begin
                rst = 1'b1; #10; rst = 1'b0; #(HALF-10);
            end else begin
                #HALF;
            end
            bclk = 1'b1;
            #HALF;
        end
    endtask

    // Model: a pair is delivered only when both slots carry all 16 data bits
    task automatic send_pair(input logic [15:0] l, input logic [15:0] r,
                             input int lp, input int rp, input bit counts);
        send_slot(1'b0, l, lp, -1, -1);
        send_slot(1'b1, r, rp, -1, -1);
        if (counts && lp >= 17 && rp >= 17) exp_q.push_back({l, r});
    endtask

    task automatic idle(input int n);
        send_slot(1'b1, 16'h0000, n, -1, -1);
    endtask

    function automatic int mag(input logic [15:0] s);
        int v;
        v = int'($signed(s));
        if (v == -32768) return 32767;
        return (v < 0) ? -v : v;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++; if (audioIn !== 32'h0) begin n_bad++; $display("FAIL reset_audioIn got %h want 0", audioIn); end
        n_cmp++; if (sampleValid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", sampleValid); end
        n_cmp++; if (frameError !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", frameError); end
`ifdef I2S_PEAK_HOLD_EN
        n_cmp++; if (peakLeft !== 16'h0 || peakRight !== 16'h0) begin n_bad++; $display("FAIL reset_peak got %h/%h want 0", peakLeft, peakRight); end
`endif
        #3;
        rst = 1'b0;
        idle(3);
    endtask

    task automatic test_basic();
        int ob = obs_q.size(); int eb = err_seen;
        exp_q.delete();
        send_pair(16'h1234, 16'hABCD, 17, 17, 1'b1);
        idle(3);
        n_cmp++; if (obs_q.size() - ob != exp_q.size()) begin n_bad++; $display("FAIL basic_count got %0d want %0d", obs_q.size() - ob, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && ob + i < obs_q.size(); i++) begin
            n_cmp++; if (obs_q[ob+i] !== exp_q[i]) begin n_bad++; $display("FAIL basic_word got %h want %h", obs_q[ob+i], exp_q[i]); end
        end
        n_cmp++; if (err_seen - eb != 0) begin n_bad++; $display("FAIL basic_err got %0d want 0", err_seen - eb); end
    endtask

    task automatic test_junk();
        int ob = obs_q.size(); int eb = err_seen;
        exp_q.delete();
        send_pair(16'h8000, 16'h7FFF, 32, 32, 1'b1);
        idle(3);
        n_cmp++; if (obs_q.size() - ob != 1) begin n_bad++; $display("FAIL junk_count got %0d want 1", obs_q.size() - ob); end
        if (obs_q.size() > ob) begin
            n_cmp++; if (obs_q[ob] !== exp_q[0]) begin n_bad++; $display("FAIL junk_word got %h want %h", obs_q[ob], exp_q[0]); end
        end
        n_cmp++; if (err_seen - eb != 0) begin n_bad++; $display("FAIL junk_err got %0d want 0", err_seen - eb); end
    endtask

    task automatic test_short_slot();
        int ob = obs_q.size(); int eb = err_seen;
        exp_q.delete();
        send_slot(1'b0, 16'($urandom), 32, -1, -1);
        send_slot(1'b1, 16'($urandom), 10, -1, -1);   // right cut after 9 data bits
        send_pair(16'h0001, 16'h0002, 32, 32, 1'b1);
        idle(3);
        n_cmp++; if (err_seen - eb != 1) begin n_bad++; $display("FAIL short_err got %0d want 1", err_seen - eb); end
        n_cmp++; if (obs_q.size() - ob != 1) begin n_bad++; $display("FAIL short_count got %0d want 1", obs_q.size() - ob); end
        if (obs_q.size() > ob) begin
            n_cmp++; if (obs_q[ob] !== exp_q[0]) begin n_bad++; $display("FAIL short_word got %h want %h", obs_q[ob], exp_q[0]); end
        end
    endtask

    task automatic test_random();
        int ob = obs_q.size(); int eb = err_seen;
        exp_q.delete();
        for (int k = 0; k < 20; k++)
            send_pair(16'($urandom), 16'($urandom), int'($urandom_range(17, 32)), int'($urandom_range(17, 32)), 1'b1);
        idle(3);
        n_cmp++; if (obs_q.size() - ob != exp_q.size()) begin n_bad++; $display("FAIL rand_count got %0d want %0d", obs_q.size() - ob, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && ob + i < obs_q.size(); i++) begin
            n_cmp++; if (obs_q[ob+i] !== exp_q[i]) begin n_bad++; $display("FAIL rand_word[%0d] got %h want %h", i, obs_q[ob+i], exp_q[i]); end
        end
        n_cmp++; if (err_seen - eb != 0) begin n_bad++; $display("FAIL rand_err got %0d want 0", err_seen - eb); end
    endtask

    task automatic test_reset_mid_right();
        int ob; int eb;
        exp_q.delete();
        rst = 1'b1;
        send_slot(1'b0, 16'($urandom), 32, -1, -1);
        send_slot(1'b1, 16'($urandom), 32, -1, 8);    // reset released mid right slot
        ob = obs_q.size(); eb = err_seen;
        send_pair(16'($urandom), 16'($urandom), 24, 24, 1'b1);
        idle(3);
        n_cmp++; if (obs_q.size() - ob != 1) begin n_bad++; $display("FAIL midrst_count got %0d want 1", obs_q.size() - ob); end
        if (obs_q.size() > ob) begin
            n_cmp++; if (obs_q[ob] !== exp_q[0]) begin n_bad++; $display("FAIL midrst_word got %h want %h", obs_q[ob], exp_q[0]); end
        end
        n_cmp++; if (err_seen - eb != 0) begin n_bad++; $display("FAIL midrst_err got %0d want 0", err_seen - eb); end
    endtask

    task automatic test_reset_pulse();
        int ob = obs_q.size(); int eb = err_seen;
        logic [31:0] after_rst;
        exp_q.delete();
        for (int k = 0; k < 5; k++)
            send_pair(16'($urandom) | 16'h1, 16'($urandom) | 16'h1, 32, 32, 1'b1);
        fork
            send_slot(1'b0, 16'($urandom), 32, 5, -1);   // sample 6 left, hit by reset
            begin
                @(negedge rst);
                @(negedge clk);
                after_rst = audioIn;
            end
        join
        send_slot(1'b1, 16'($urandom), 32, -1, -1);
        send_pair(16'($urandom), 16'($urandom), 32, 32, 1'b1);
        idle(3);
        n_cmp++; if (after_rst !== 32'h0) begin n_bad++; $display("FAIL pulse_clear got %h want 0", after_rst); end
        n_cmp++; if (obs_q.size() - ob != exp_q.size()) begin n_bad++; $display("FAIL pulse_count got %0d want %0d", obs_q.size() - ob, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && ob + i < obs_q.size(); i++) begin
            n_cmp++; if (obs_q[ob+i] !== exp_q[i]) begin n_bad++; $display("FAIL pulse_word[%0d] got %h want %h", i, obs_q[ob+i], exp_q[i]); end
        end
        n_cmp++; if (err_seen - eb != 0) begin n_bad++; $display("FAIL pulse_err got %0d want 0", err_seen - eb); end
    endtask

`ifdef I2S_PEAK_HOLD_EN
    task automatic test_peak();
        logic [15:0] ls[3];
        logic [15:0] rs[3];
        int pl; int pr;
        ls[0] = 16'h8000; rs[0] = 16'd5;
        ls[1] = 16'd100;  rs[1] = 16'd5;
        ls[2] = 16'd3;    rs[2] = 16'd4;
        rst = 1'b1;
        send_slot(1'b1, 16'h0, 4, -1, 2);
        pl = 0; pr = 0;
        for (int k = 0; k < 2; k++) begin
            send_pair(ls[k], rs[k], 32, 32, 1'b0);
            if (mag(ls[k]) > pl) pl = mag(ls[k]);
            if (mag(rs[k]) > pr) pr = mag(rs[k]);
        end
        idle(3);
        n_cmp++; if (peakLeft !== 16'(pl)) begin n_bad++; $display("FAIL peak_left got %0d want %0d", peakLeft, pl); end
        n_cmp++; if (peakRight !== 16'(pr)) begin n_bad++; $display("FAIL peak_right got %0d want %0d", peakRight, pr); end
        peakClr = 1'b1;
        send_pair(ls[2], rs[2], 32, 32, 1'b0);
        idle(3);
        peakClr = 1'b0;
        pl = mag(ls[2]); pr = mag(rs[2]);
        n_cmp++; if (peakLeft !== 16'(pl)) begin n_bad++; $display("FAIL peakclr_left got %0d want %0d", peakLeft, pl); end
        n_cmp++; if (peakRight !== 16'(pr)) begin n_bad++; $display("FAIL peakclr_right got %0d want %0d", peakRight, pr); end
        n_cmp++; if (audioIn !== {ls[2], rs[2]}) begin n_bad++; $display("FAIL peak_word got %h want %h", audioIn, {ls[2], rs[2]}); end
    endtask
`endif

    initial begin
        #3;
        test_reset();
        test_basic();
        test_junk();
        test_short_slot();
        test_random();
        test_reset_mid_right();
        test_reset_pulse();
`ifdef I2S_PEAK_HOLD_EN
        test_peak();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/i2s_adc_rx.md
Name: i2s_adc_rx

Overview:
- Upstream stage of the audio filter path. Deserializes the codec ADC I2S stream into one packed 32-bit stereo word per LR frame: left in [31:16], right in [15:0].
- Raises a one-cycle strobe when a complete left+right pair is ready for the filter.
- Runs entirely on the system clock. Codec clock pins are treated as asynchronous data: they are synchronized and edge-detected.

Parameters:
- SAMPLE_WIDTH, 16: bits captured per channel, MSB-first. Any bits beyond this in a channel slot are ignored.
- SYNC_STAGES, 2: flip-flop depth of the input synchronizers (minimum 2).

Ports:
- clk  in  1  system clock; all logic is on posedge clk
- rst  in  1  synchronous, active-high reset
- AUD_BCLK  in  1  codec bit clock, asynchronous to clk
- AUD_ADCLRCK  in  1  codec ADC LR clock, asynchronous; low = left, high = right
- AUD_ADCDAT  in  1  codec ADC serial data, asynchronous
- audioIn  out  32  {left[15:0], right[15:0]}, two's complement; holds the last complete pair
- sampleValid  out  1  one-clk pulse, asserted when audioIn updates
- frameError  out  1  one-clk pulse on a short or misaligned channel slot

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: audioIn = 0, sampleValid = 0, frameError = 0, FSM = ALIGN, shift register and bit counter = 0.
- Input conditioning:
  - BCLK, LRCK and DAT each pass through SYNC_STAGES flops.
  - bclkRise = sync & ~prev. lrEdge = sync ^ prev. lrFall = ~sync & prev.
  - DAT is sampled from its synchronized copy in the bclkRise cycle.
- Protocol: standard I2S. After each LRCK transition, the first BCLK rising edge is the delay slot. The MSB is captured on the second rising edge.
- FSM states:
  - ALIGN: ignore everything until lrFall (start of a left slot) -> DELAY, channel = L.
  - DELAY: on bclkRise -> SHIFT, bitCnt = 0.
  - SHIFT: on bclkRise, shift DAT into the LSB and increment bitCnt. When bitCnt reaches SAMPLE_WIDTH-1 on a bclkRise, the word is complete:
    - left: store in leftHold -> DRAIN.
    - right: audioIn <= {leftHold, word}, sampleValid = 1 next cycle -> DRAIN.
  - DRAIN: ignore extra bclkRise. On lrEdge -> DELAY, toggle channel.
- Latency: audioIn and sampleValid change on the clk edge after the bclkRise cycle that captures the right LSB. sampleValid is high for exactly one clk.
- Short slot: lrEdge while in DELAY or SHIFT.
  - Pulse frameError for one clk and discard the partial word.
  - Discard the pending leftHold; no sampleValid is issued for that pair.
  - Go to DELAY on the new slot if it is left (lrFall). If it is right, go to ALIGN.
- Simultaneous lrEdge and bclkRise in the same clk: lrEdge takes priority, and that bclkRise is consumed as the delay slot of the new channel.
- Wrong-channel edge: an lrEdge in DRAIN whose polarity disagrees with the expected next channel pulses frameError -> ALIGN.
- Reset mid-frame: every state returns to ALIGN and outputs clear the next cycle. No sampleValid is issued until a full left+right pair follows the first lrFall.
- Arithmetic: none; the data path is a pure shift.

Optional Feature:
- Macro: I2S_PEAK_HOLD_EN.
- When defined:
  - Adds output peakLeft [15:0] and output peakRight [15:0].
  - Each holds the maximum |sample| seen since reset or since the last sampleValid on which input peakClr (1 bit) was high.
  - The magnitude of -32768 saturates to 32767.
  - Peaks update in the same cycle as audioIn.
- When undefined: these ports and their registers do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package audio_pkg holds:
  - the SAMPLE_WIDTH default (16);
  - the FSM state enum {ALIGN, DELAY, SHIFT, DRAIN};
  - the channel constants CH_LEFT = 0 and CH_RIGHT = 1;
  - the packed-word field positions (left [31:16], right [15:0]).
- One sub-module, sync_edge_detect: SYNC_STAGES synchronizer plus rise/fall/any-edge outputs, instantiated three times (BCLK, LRCK, DAT, with DAT using only the sync output).

Test Plan:
- Stimulus: BCLK = clk/8; left 0x1234, right 0xABCD in I2S after reset. Response: one sampleValid with audioIn = 0x1234ABCD; nothing else.
- Stimulus: 32-bit slots, left 0x8000 plus 16 junk bits, right 0x7FFF plus junk. Response: audioIn = 0x80007FFF; junk ignored.
- Stimulus: right slot cut after 9 bits by an LRCK edge. Response: frameError pulses once; no sampleValid for that pair; next full pair 0x00010002 is delivered correctly.
- Stimulus: reset released mid-right-slot. Response: no output until the following lrFall; the first sampleValid carries the next complete pair.
- Stimulus: rst asserted for 1 clk during a left SHIFT after 5 valid pairs. Response: audioIn = 0 the next cycle; resynchronizes; sample 6 is lost and sample 7 is correct.
- With I2S_PEAK_HOLD_EN: Stimulus: samples L = -32768, then 100; R = 5. Response: peakLeft = 32767, peakRight = 5. Stimulus: peakClr high on the next pair with values (3, 4). Response: peakLeft = 3, peakRight = 4.
